// File: rtl/input_conditioner_pkg.sv
// Shared traffic-light definitions for the input conditioner.
// Holds the default debounce length, the button index constants and the
// order in which simultaneous button presses are granted.
// Optional debounce counters are enabled by INPUT_CONDITIONER_DEBOUNCE_EN.
package input_conditioner_pkg;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    localparam int NUM_BTNS = 3;
    localparam int NUM_SWS  = 2;

    typedef enum logic [1:0] {
        BTN_AUTO   = 2'd0,
        BTN_NIGHT  = 2'd1,
        BTN_MANUAL = 2'd2
    } btn_idx_e;

    // Highest priority first: auto wins over night, night over manual
    localparam btn_idx_e PRIORITY_ORDER [NUM_BTNS] = '{BTN_AUTO, BTN_NIGHT, BTN_MANUAL};

    // Returns a one-hot grant for the highest-priority candidate; losers are dropped
    function automatic logic [NUM_BTNS-1:0] priority_pick(input logic [NUM_BTNS-1:0] cand);
        logic [NUM_BTNS-1:0] grant;
        grant = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (cand[PRIORITY_ORDER[i]] && (grant == '0)) begin
                grant[PRIORITY_ORDER[i]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// debounce_cell: two-flop synchronizer followed by an optional
// consecutive-stable-cycles debouncer for one mechanical input.
// With INPUT_CONDITIONER_DEBOUNCE_EN undefined the counter is compiled out
// and the level output is simply the synchronized input.
module debounce_cell
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic sync_meta;
    logic sync_out;

    // Bring the asynchronous raw input into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          state;
    logic [CW-1:0] count;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= 1'b0;
            count <= '0;
        end else if (sync_out == state) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            state <= sync_out;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign level = state;
`else
    assign level = sync_out;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: conditions three push-buttons and two slide switches
// for the traffic-light mode controller. Each input is synchronized and
// debounced in its own debounce_cell; this level turns button presses into
// single-cycle, priority-resolved pulses and registers the switch levels.
// Debounce counters are present only with INPUT_CONDITIONER_DEBOUNCE_EN.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1_raw,
    input  logic btn2_raw,
    input  logic btn3_raw,
    input  logic sw1_raw,
    input  logic sw2_raw,
    output logic btn1,
    output logic btn2,
    output logic btn3,
    output logic sw1,
    output logic sw2
);

    localparam int NUM_INPUTS = NUM_BTNS + NUM_SWS;

    logic [NUM_INPUTS-1:0] raw_bus;
    logic [NUM_INPUTS-1:0] levels;
    logic [NUM_BTNS-1:0]   btn_level;
    logic [NUM_BTNS-1:0]   btn_prev;
    logic [NUM_BTNS-1:0]   btn_cand;
    logic [NUM_BTNS-1:0]   btn_grant;
    logic [NUM_BTNS-1:0]   btn_out;
    logic [NUM_SWS-1:0]    sw_out;

    assign raw_bus = {sw2_raw, sw1_raw, btn3_raw, btn2_raw, btn1_raw};

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_bus[g]),
            .level (levels[g])
        );
    end

    assign btn_level = levels[NUM_BTNS-1:0];
    assign btn_cand  = btn_level & ~btn_prev;
    assign btn_grant = priority_pick(btn_cand);

    // Remember last debounced button levels and register the granted pulse and switch levels
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= '0;
            btn_out  <= '0;
            sw_out   <= '0;
        end else begin
            btn_prev <= btn_level;
            btn_out  <= btn_grant;
            sw_out   <= levels[NUM_INPUTS-1:NUM_BTNS];
        end
    end

    assign btn1 = btn_out[BTN_AUTO];
    assign btn2 = btn_out[BTN_NIGHT];
    assign btn3 = btn_out[BTN_MANUAL];
    assign sw1  = sw_out[0];
    assign sw2  = sw_out[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 8.
// Expected outputs come from an edge-indexed history model: the debounced
// level flips once the synchronized input has disagreed with it for the
// last DEBOUNCE_CYCLES edges. Works with INPUT_CONDITIONER_DEBOUNCE_EN
// defined or undefined.
module tb_input_conditioner;

    localparam int DC   = 8;
    localparam int MAXE = 4096;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = DC + 3;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn1_raw = 1'b0, btn2_raw = 1'b0, btn3_raw = 1'b0;
    logic sw1_raw = 1'b0, sw2_raw = 1'b0;
    logic btn1, btn2, btn3, sw1, sw2;

    input_conditioner #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn1_raw (btn1_raw),
        .btn2_raw (btn2_raw),
        .btn3_raw (btn3_raw),
        .sw1_raw  (sw1_raw),
        .sw2_raw  (sw2_raw),
        .btn1     (btn1),
        .btn2     (btn2),
        .btn3     (btn3),
        .sw1      (sw1),
        .sw2      (sw2)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int edge_n = 0;

    // Reference model state: raw samples per edge, debounced levels, previous button levels
    logic [4:0] hist [0:MAXE-1];
    logic [4:0] m_state = '0;
    logic [2:0] m_prev = '0;
    int         last_rst = 0;
    logic [4:0] exp_out = '0;

    // Observation tracking
    int   pulses [3];
    int   last_pulse [3];
    int   sw1_rise, sw1_fall;
    logic sw1_q = 1'b0;

    logic [4:0] stim = '0;
    int t0, rel;

    function automatic logic syncAt(input int n, input int i);
        if (n < 2) return 1'b0;
        return hist[n-2][i];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic [4:0] r, input logic rst);
        logic [4:0] db;
        logic [2:0] cand;
        logic       flip;
        int n;
        n = edge_n;
        if (rst) begin
            hist[n] = '0;
            if (n >= 1) hist[n-1] = '0;
            m_state  = '0;
            m_prev   = '0;
            last_rst = n;
            exp_out  = '0;
        end else begin
            hist[n] = r;
            for (int i = 0; i < 5; i++) begin
                db[i] = DEB ? m_state[i] : syncAt(n, i);
                flip = (n - last_rst >= DC);
                for (int k = 0; k < DC; k++) begin
                    if (syncAt(n - k, i) == m_state[i]) flip = 1'b0;
                end
                if (flip) m_state[i] = ~m_state[i];
            end
            cand   = db[2:0] & ~m_prev;
            m_prev = db[2:0];
            exp_out = {db[4], db[3], 3'b000};
            if (cand[0])      exp_out[0] = 1'b1;
            else if (cand[1]) exp_out[1] = 1'b1;
            else if (cand[2]) exp_out[2] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] r, input logic rst);
        {sw2_raw, sw1_raw, btn3_raw, btn2_raw, btn1_raw} = r;
        reset = rst;
        @(posedge clk);
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("[TB] FAIL edge_budget: observed %0d expected below %0d", edge_n, MAXE);
            $fatal(1, "[TB] edge budget exhausted");
        end
        modelStep(r, rst);
        #1;
        checkOutput("btn1", btn1, exp_out[0]);
        checkOutput("btn2", btn2, exp_out[1]);
        checkOutput("btn3", btn3, exp_out[2]);
        checkOutput("sw1",  sw1,  exp_out[3]);
        checkOutput("sw2",  sw2,  exp_out[4]);
        if (btn1 === 1'b1) begin pulses[0]++; last_pulse[0] = edge_n; end
        if (btn2 === 1'b1) begin pulses[1]++; last_pulse[1] = edge_n; end
        if (btn3 === 1'b1) begin pulses[2]++; last_pulse[2] = edge_n; end
        if (sw1 !== sw1_q) begin
            if (sw1 === 1'b1) sw1_rise = edge_n;
            else              sw1_fall = edge_n;
        end
        sw1_q = sw1;
    endtask

    task automatic clearTrack();
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            last_pulse[i] = -1;
        end
        sw1_rise = -1;
        sw1_fall = -1;
    endtask

    task automatic stepIdle(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(stim, 1'b0);
    endtask

    initial begin
        $display("[TB] start, debounce %0d, latency %0d", DEB, LAT);
        clearTrack();

        // Reset state
        repeat (3) applyStimulus(5'b0, 1'b1);
        checkOutput("reset_btn1", btn1, 0);
        checkOutput("reset_sw1", sw1, 0);
        stepIdle(2);

        // Held press: one pulse at the expected latency, nothing more while held
        clearTrack();
        t0 = edge_n;
        stim[0] = 1'b1;
        stepIdle(40);
        checkOutput("held_btn1_count", pulses[0], 1);
        checkOutput("held_btn1_edge", last_pulse[0], t0 + LAT);
        checkOutput("held_btn2_count", pulses[1], 0);
        checkOutput("held_btn3_count", pulses[2], 0);
        stim[0] = 1'b0;
        stepIdle(LAT + 4);

        // Short bounces on btn2 are filtered, then a long press gives one pulse
        clearTrack();
        for (int g = 0; g < 4; g++) begin
            stim[1] = 1'b1;
            stepIdle(5);
            stim[1] = 1'b0;
            stepIdle(5);
        end
        stepIdle(LAT + 2);
        checkOutput("bounce_btn2_count", pulses[1], DEB ? 0 : 4);
        clearTrack();
        stim[1] = 1'b1;
        stepIdle(20);
        stim[1] = 1'b0;
        stepIdle(LAT + 2);
        checkOutput("long_btn2_count", pulses[1], 1);

        // Simultaneous presses: only the highest priority button pulses
        clearTrack();
        t0 = edge_n;
        stim[2:0] = 3'b111;
        stepIdle(LAT + 10);
        checkOutput("prio_btn1_count", pulses[0], 1);
        checkOutput("prio_btn1_edge", last_pulse[0], t0 + LAT);
        checkOutput("prio_btn2_count", pulses[1], 0);
        checkOutput("prio_btn3_count", pulses[2], 0);
        stim[2:0] = 3'b000;
        stepIdle(LAT + 4);

        // Switch level follows with the same latency on rise and fall
        clearTrack();
        t0 = edge_n;
        stim[3] = 1'b1;
        stepIdle(30);
        stim[3] = 1'b0;
        stepIdle(LAT + 5);
        checkOutput("sw1_rise_edge", sw1_rise, t0 + LAT);
        checkOutput("sw1_fall_edge", sw1_fall, t0 + 30 + LAT);

        // Reset in the middle of a btn3 debounce; press held through release
        stim[2] = 1'b1;
        stepIdle(7);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(stim, 1'b1);
            checkOutput("rst_mid_btn1", btn1, 0);
            checkOutput("rst_mid_btn2", btn2, 0);
            checkOutput("rst_mid_btn3", btn3, 0);
            checkOutput("rst_mid_sw1", sw1, 0);
            checkOutput("rst_mid_sw2", sw2, 0);
        end
        rel = edge_n;
        clearTrack();
        stepIdle(LAT + 8);
        checkOutput("rst_btn3_count", pulses[2], 1);
        checkOutput("rst_btn3_edge", last_pulse[2], rel + LAT);
        stim[2] = 1'b0;
        stepIdle(LAT + 4);

        // Single-cycle glitch on btn1
        clearTrack();
        stim[0] = 1'b1;
        stepIdle(1);
        stim[0] = 1'b0;
        stepIdle(LAT + 6);
        checkOutput("glitch_btn1_count", pulses[0], DEB ? 0 : 1);

        // Random slowly-changing inputs with occasional resets, checked cycle by cycle
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(7) == 0) stim[i] = ~stim[i];
            end
            applyStimulus(stim, ($urandom_range(149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
